pc_fetch: RTL and testbench

- Program counter and instruction-fetch sequencer; the consumer of the branch unit's branch decision.
- Holds the PC and fetches each instruction word from program memory over a req/ack handshake.
- Presents the instruction to the control unit and waits for it to finish executing.
- On completion, either increments to the next instruction or loads the branch target from the instruction operand.

---
 rtl/pc_fetch.sv | 101 ++++++++++
 tb/tb_pc_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch sequencer.
//
// Holds the PC, fetches each instruction word from program memory over a
// req/ack handshake, presents it to the control unit, and waits for the
// control unit to signal completion.  On completion the PC either keeps its
// post-fetch increment or loads the branch target from the operand field.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   run_i        fetch enable, sampled in IDLE and at instruction end
//   mem_req_o    fetch request, held until mem_ack_i
//   mem_addr_o   fetch address (equals pc_o)
//   mem_ack_i    memory acknowledge, mem_data_i valid in the same cycle
//   mem_data_i   fetched instruction word
//   ir_o         instruction register
//   op_o         opcode field of ir_o
//   ir_valid_o   one-cycle pulse in the first EXEC cycle
//   exec_done_i  current instruction complete
//   branch_i     taken-branch decision, sampled with exec_done_i
//   halt_i       halt request, sampled with exec_done_i
//   pc_o         current program counter
//   halted_o     high in HALTED
module pc_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              run_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] ir_o,
  output logic [2:0]        op_o,
  output logic              ir_valid_o,
  input  logic              exec_done_i,
  input  logic              branch_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run_i) state <= FETCH;
        end
        FETCH: begin
          if (mem_ack_i) begin
            ir       <= mem_data_i;
            pc       <= pc + ADDR_W'(1);
            ir_valid <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done_i) begin
            // Branch load applies even when halting in the same cycle.
            if (branch_i) pc <= ir[ADDR_W-1:0];
            if (halt_i)     state <= HALTED;
            else if (run_i) state <= FETCH;
            else            state <= IDLE;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign mem_req_o  = (state == FETCH);
  assign mem_addr_o = pc;
  assign halted_o   = (state == HALTED);
  assign pc_o       = pc;
  assign ir_o       = ir;
  assign ir_valid_o = ir_valid;
  assign op_o       = ir[DATA_W-1:DATA_W-3];

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              run_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] ir_o;
  logic [2:0]        op_o;
  logic              ir_valid_o;
  logic              exec_done_i;
  logic              branch_i;
  logic              halt_i;
  logic [ADDR_W-1:0] pc_o;
  logic              halted_o;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state.
  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_ir;
  logic              m_halted;

  pc_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .run_i      (run_i),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .ir_o       (ir_o),
    .op_o       (op_o),
    .ir_valid_o (ir_valid_o),
    .exec_done_i(exec_done_i),
    .branch_i   (branch_i),
    .halt_i     (halt_i),
    .pc_o       (pc_o),
    .halted_o   (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0; run_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    exec_done_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_pc = '0; m_ir = '0; m_halted = 1'b0;
  endtask

  // One full instruction: fetch with ack_dly wait cycles, exec with exec_dly
  // wait cycles, then completion with the given branch/halt/run.
  task automatic run_instr(input logic [DATA_W-1:0] d, input int unsigned ack_dly,
                           input int unsigned exec_dly, input logic br,
                           input logic hl, input logic rn, input string tag);
    int unsigned w;
    logic [ADDR_W-1:0] fpc;
    logic exp_req;
    if (!mem_req_o) begin
      run_i = 1'b1;
      w = 0;
      while (!mem_req_o && w < 20) begin @(negedge clk); w++; end
    end
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL %s req_timeout got=%b exp=1", tag, mem_req_o);
      return;
    end
    fpc = m_pc;
    checks++;
    if (mem_addr_o !== fpc) begin
      errors++; $display("FAIL %s fetch_addr got=%0d exp=%0d", tag, mem_addr_o, fpc);
    end
    for (int k = 0; k < int'(ack_dly); k++) begin
      mem_ack_i = 1'b0; mem_data_i = DATA_W'($urandom);
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== fpc) begin
        errors++;
        $display("FAIL %s req_hold got=%b/%0d exp=1/%0d", tag, mem_req_o, mem_addr_o, fpc);
      end
    end
    mem_ack_i = 1'b1; mem_data_i = d;
    @(negedge clk);
    mem_ack_i = 1'b0; mem_data_i = DATA_W'($urandom);
    m_ir = d;
    m_pc = m_pc + 1'b1;
    checks++;
    if (ir_valid_o !== 1'b1 || ir_o !== d || op_o !== d[7:5] || pc_o !== m_pc || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s exec_entry got=v%b ir%h op%0d pc%0d req%b exp=v1 ir%h op%0d pc%0d req0",
               tag, ir_valid_o, ir_o, op_o, pc_o, mem_req_o, d, d[7:5], m_pc);
    end
    for (int k = 0; k < int'(exec_dly); k++) begin
      exec_done_i = 1'b0;
      branch_i = 1'($urandom); halt_i = 1'($urandom);
      mem_ack_i = 1'($urandom); run_i = 1'($urandom);
      @(negedge clk);
      checks++;
      if (ir_valid_o !== 1'b0 || pc_o !== m_pc || ir_o !== m_ir || mem_req_o !== 1'b0 || halted_o !== 1'b0) begin
        errors++;
        $display("FAIL %s exec_wait got=v%b pc%0d ir%h req%b h%b exp=v0 pc%0d ir%h req0 h0",
                 tag, ir_valid_o, pc_o, ir_o, mem_req_o, halted_o, m_pc, m_ir);
      end
    end
    exec_done_i = 1'b1; branch_i = br; halt_i = hl; run_i = rn; mem_ack_i = 1'b0;
    @(negedge clk);
    exec_done_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0;
    if (br) m_pc = m_ir[ADDR_W-1:0];
    m_halted = hl;
    exp_req = !hl && rn;
    checks++;
    if (pc_o !== m_pc || halted_o !== m_halted || mem_req_o !== exp_req || ir_o !== m_ir || ir_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s exec_end got=pc%0d h%b req%b ir%h v%b exp=pc%0d h%b req%b ir%h v0",
               tag, pc_o, halted_o, mem_req_o, ir_o, ir_valid_o, m_pc, m_halted, exp_req, m_ir);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc_o !== '0 || ir_o !== '0 || mem_req_o !== 1'b0 || ir_valid_o !== 1'b0 || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=pc%0d ir%h req%b v%b h%b exp=0 0 0 0 0",
               pc_o, ir_o, mem_req_o, ir_valid_o, halted_o);
    end
    // Acks while idle are ignored.
    mem_ack_i = 1'b1; mem_data_i = 8'hFF;
    repeat (3) @(negedge clk);
    mem_ack_i = 1'b0;
    checks++;
    if (ir_o !== '0 || pc_o !== '0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack got=ir%h pc%0d req%b exp=ir00 pc0 req0", ir_o, pc_o, mem_req_o);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    run_instr(8'h41, 0, 0, 1'b0, 1'b0, 1'b1, "lda1");
    checks++;
    if (mem_addr_o !== 5'd1 || op_o !== 3'b010) begin
      errors++;
      $display("FAIL lda1_next got=addr%0d op%0d exp=addr1 op2", mem_addr_o, op_o);
    end
  endtask

  task automatic test_jmp();
    run_instr(8'h8A, 0, 1, 1'b1, 1'b0, 1'b1, "jmp10");
    checks++;
    if (mem_addr_o !== 5'd10 || pc_o !== 5'd10) begin
      errors++;
      $display("FAIL jmp10_addr got=addr%0d pc%0d exp=10", mem_addr_o, pc_o);
    end
  endtask

  task automatic test_jz_not_taken();
    do_reset();
    run_instr(8'hAC, 0, 2, 1'b0, 1'b0, 1'b0, "jz_nt");
    checks++;
    if (pc_o !== 5'd1) begin
      errors++; $display("FAIL jz_nt_pc got=%0d exp=1", pc_o);
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    run_instr(8'h23, 3, 2, 1'b0, 1'b0, 1'b1, "ack_dly3");
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(8'h9F, 0, 0, 1'b1, 1'b0, 1'b1, "jmp31");
    run_instr(8'h10, 1, 0, 1'b0, 1'b0, 1'b1, "wrap");
    checks++;
    if (pc_o !== 5'd0 || mem_addr_o !== 5'd0) begin
      errors++; $display("FAIL wrap_pc got=pc%0d addr%0d exp=0", pc_o, mem_addr_o);
    end
  endtask

  task automatic test_halt_branch();
    do_reset();
    run_instr(8'h03, 0, 0, 1'b0, 1'b0, 1'b1, "pre_halt");
    run_instr(8'hE5, 0, 1, 1'b1, 1'b1, 1'b1, "halt_br");
    for (int k = 0; k < 10; k++) begin
      run_i = 1'b1; mem_ack_i = 1'($urandom); mem_data_i = DATA_W'($urandom);
      exec_done_i = 1'($urandom); branch_i = 1'($urandom); halt_i = 1'($urandom);
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0 || halted_o !== 1'b1 || pc_o !== 5'd5 || ir_o !== 8'hE5) begin
        errors++;
        $display("FAIL halted_hold got=req%b h%b pc%0d ir%h exp=req0 h1 pc5 irE5",
                 mem_req_o, halted_o, pc_o, ir_o);
      end
    end
    exec_done_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run_instr(8'h41, 0, 0, 1'b0, 1'b0, 1'b1, "pre_rst");
    mem_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b1 || pc_o !== 5'd1) begin
      errors++; $display("FAIL pre_rst_fetch got=req%b pc%0d exp=req1 pc1", mem_req_o, pc_o);
    end
    mem_ack_i = 1'b1; mem_data_i = 8'h77;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || pc_o !== '0 || ir_o !== '0 || halted_o !== 1'b0 || ir_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got=req%b pc%0d ir%h h%b v%b exp=0", mem_req_o, pc_o, ir_o, halted_o, ir_valid_o);
    end
    @(negedge clk);
    run_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack_i = 1'b0;
    checks++;
    if (mem_req_o !== 1'b0 || pc_o !== '0 || ir_o !== '0) begin
      errors++; $display("FAIL rst_idle got=req%b pc%0d ir%h exp=req0 pc0 ir00", mem_req_o, pc_o, ir_o);
    end
    m_pc = '0; m_ir = '0; m_halted = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      if (m_halted) do_reset();
      run_instr(DATA_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), "rand");
    end
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    exec_done_i = 1'b0; branch_i = 1'b0; halt_i = 1'b0;
    m_pc = '0; m_ir = '0; m_halted = 1'b0;
    test_reset();
    test_first_fetch();
    test_jmp();
    test_jz_not_taken();
    test_ack_delay();
    test_wrap();
    test_halt_branch();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
